// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling and a valid/ready output register
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 1300,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 m_clock,
   input  logic                 p_reset,
   input  logic                 RDX,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] TC_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] TC_HALF = CW'(HALF - 1);
   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic PAR_ODD = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

   state_t               state, state_nx;
   logic [1:0]           sync;
   logic                 rxs;
   logic [CW-1:0]        cnt;
   logic [3:0]           idx;
   logic [DATA_BITS-1:0] sh;
   logic                 perr_q, ferr_q;
   logic                 sample, done, ferr_fin, perr_now;

   assign rxs  = sync[1];
   assign busy = (state != IDLE);

   // two-flop synchroniser, reset high so a reset line never looks like a start bit
   always_ff @(posedge m_clock or negedge p_reset)
      if (!p_reset) sync <= 2'b11;
      else sync <= {sync[0], RDX};

   // state register
   always_ff @(posedge m_clock or negedge p_reset)
      if (!p_reset) state <= IDLE;
      else state <= state_nx;

   // sample strobe, frame completion and next-state decode
   always_comb begin
      state_nx = state;
      done     = 1'b0;
      sample   = (state == START) ? (cnt == TC_HALF) : (cnt == TC_FULL);
      ferr_fin = ferr_q | ~rxs;
      perr_now = ((^sh) ^ rxs) != PAR_ODD;
      case (state)
         IDLE:  if (!rxs) state_nx = START;
         START: if (sample) state_nx = rxs ? IDLE : DATA;
         DATA:  if (sample && idx == LAST_DATA) state_nx = (PARITY != 0) ? PAR : STOP;
         PAR:   if (sample) state_nx = STOP;
         STOP:  if (sample && idx == LAST_STOP) begin
                   done     = 1'b1;
                   state_nx = ferr_fin ? BRK : IDLE;
                end
         BRK:   if (rxs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // baud counter, bit index, data shifter and per-frame error latches
   always_ff @(posedge m_clock or negedge p_reset)
      if (!p_reset) begin
         cnt    <= '0;
         idx    <= '0;
         sh     <= '0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else if (state == IDLE || state == BRK) begin
         cnt    <= '0;
         idx    <= '0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else if (sample) begin
         cnt <= '0;
         idx <= (state_nx != state) ? 4'd0 : idx + 4'd1;
         if (state == DATA) sh <= {rxs, sh[DATA_BITS-1:1]};
         if (state == PAR) perr_q <= perr_now;
         if (state == STOP && !rxs) ferr_q <= 1'b1;
      end else cnt <= cnt + 1'b1;

   // single-entry output register: load on completion unless full and not being drained
   always_ff @(posedge m_clock or negedge p_reset)
      if (!p_reset) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= done & rx_valid & ~rx_ready;
         if (done && (!rx_valid || rx_ready)) begin
            rx_data    <= sh;
            parity_err <= perr_q;
            frame_err  <= ferr_fin;
            rx_valid   <= 1'b1;
         end else if (rx_ready) rx_valid <= 1'b0;
      end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed vector bench for uart_rx_param (8N1 instance and 7E2 instance)
module tb_uart_rx_param;
   localparam int CPB = 16;

   typedef struct {
      bit         sel;
      logic [8:0] d;
      bit         flip;
      logic [8:0] exp_d;
      bit         exp_pe;
      int         exp_cyc;
   } vec_t;

   logic       m_clock = 0, p_reset = 1;
   logic       rdx_a = 1, rdx_b = 1, ready_a = 1, ready_b = 1;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;
   logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;
   int         total = 0, bad = 0;
   int         cyc, nb, nv, no;
   logic [8:0] d;
   logic       pe, fe;
   vec_t       vecs[9];
   vec_t       v1;

   always #5 m_clock = ~m_clock;

   uart_rx_param #(.CLKS_PER_BIT(CPB)) dut_a (
      .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx_a),
      .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
      .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .busy(busy_a));

   uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
      .m_clock(m_clock), .p_reset(p_reset), .RDX(rdx_b),
      .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
      .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .busy(busy_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // line bits LSB first: start, data, [parity], stop(s)
   function automatic logic [15:0] frame(input bit sel, input logic [8:0] x, input bit flip);
      return sel ? {5'b0, 2'b11, (^x[6:0]) ^ flip, x[6:0], 1'b0} : {6'b0, 1'b1, x[7:0], 1'b0};
   endfunction

   task automatic drive_bits(input bit sel, input logic [15:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) rdx_b = f[i]; else rdx_a = f[i];
         repeat (CPB) @(negedge m_clock);
      end
   endtask

   task automatic wait_valid(input bit sel, input int lim, output int c, output logic [8:0] x,
                             output logic p, output logic f);
      c = 0; x = 'x; p = 'x; f = 'x;
      while (c < lim) begin
         @(posedge m_clock); #1; c++;
         if (sel ? valid_b : valid_a) begin
            x = sel ? {2'b0, data_b} : {1'b0, data_a};
            p = sel ? perr_b : perr_a;
            f = sel ? ferr_b : ferr_a;
            break;
         end
      end
   endtask

   // latency counts posedges from the negedge where the start bit is driven:
   // 2 sync edges + HALF + N*CPB + 1
   task automatic run_vec(input vec_t v, input string tag);
      @(negedge m_clock);
      fork
         drive_bits(v.sel, frame(v.sel, v.d, v.flip), v.sel ? 11 : 10);
         wait_valid(v.sel, 400, cyc, d, pe, fe);
      join
      chk({tag, " latency"}, cyc, v.exp_cyc);
      chk({tag, " data"}, d, v.exp_d);
      chk({tag, " parity_err"}, pe, v.exp_pe);
      chk({tag, " frame_err"}, fe, 0);
      repeat (3) @(negedge m_clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 9'h55, 1'b0, 9'h55, 1'b0, 155};
      vecs[1] = '{1'b0, 9'hA3, 1'b0, 9'hA3, 1'b0, 155};
      vecs[2] = '{1'b0, 9'h00, 1'b0, 9'h00, 1'b0, 155};
      vecs[3] = '{1'b0, 9'hFF, 1'b0, 9'hFF, 1'b0, 155};
      vecs[4] = '{1'b0, 9'h01, 1'b0, 9'h01, 1'b0, 155};
      vecs[5] = '{1'b1, 9'h41, 1'b0, 9'h41, 1'b0, 171};
      vecs[6] = '{1'b1, 9'h41, 1'b1, 9'h41, 1'b1, 171};
      vecs[7] = '{1'b1, 9'h7F, 1'b0, 9'h7F, 1'b0, 171};
      vecs[8] = '{1'b1, 9'h2A, 1'b1, 9'h2A, 1'b1, 171};
      #1 p_reset = 0;
      repeat (3) @(negedge m_clock);
      chk("rst valid_a", valid_a, 0);
      chk("rst data_a", data_a, 0);
      chk("rst flags_a", {perr_a, ferr_a, ovr_a}, 0);
      chk("rst busy_a", busy_a, 0);
      chk("rst valid_b", valid_b, 0);
      chk("rst busy_b", busy_b, 0);
      p_reset = 1;
      repeat (3) @(negedge m_clock);
      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
      // short low pulse must be rejected at the start sample
      @(negedge m_clock);
      nb = 0; nv = 0;
      fork
         begin rdx_a = 0; repeat (4) @(negedge m_clock); rdx_a = 1; end
         repeat (40) begin @(posedge m_clock); #1; nb += int'(busy_a); nv += int'(valid_a); end
      join
      chk("glitch busy window", (nb >= 1 && nb <= 9), 1);
      chk("glitch no valid", nv, 0);
      chk("glitch idle", busy_a, 0);
      // line held low for 30 bit times: one 0x00 word with frame_err, then stuck in break
      @(negedge m_clock);
      rdx_a = 0; nv = 0; d = 'x; pe = 'x; fe = 'x;
      repeat (30 * CPB) begin
         @(posedge m_clock); #1;
         if (valid_a) begin nv++; d = {1'b0, data_a}; pe = perr_a; fe = ferr_a; end
      end
      chk("break words", nv, 1);
      chk("break data", d, 0);
      chk("break frame_err", fe, 1);
      chk("break parity_err", pe, 0);
      chk("break busy", busy_a, 1);
      @(negedge m_clock);
      rdx_a = 1;
      repeat (5) @(negedge m_clock);
      chk("break exit", busy_a, 0);
      v1 = '{1'b0, 9'h3C, 1'b0, 9'h3C, 1'b0, 155};
      run_vec(v1, "after break");
      // consumer stalls across two frames
      ready_a = 0;
      v1 = '{1'b0, 9'h11, 1'b0, 9'h11, 1'b0, 155};
      run_vec(v1, "ovr first");
      @(negedge m_clock);
      no = 0;
      fork
         drive_bits(1'b0, frame(1'b0, 9'h22, 1'b0), 10);
         repeat (170) begin @(posedge m_clock); #1; no += int'(ovr_a); end
      join
      chk("overrun pulses", no, 1);
      chk("overrun keeps data", data_a, 8'h11);
      chk("overrun keeps valid", valid_a, 1);
      // accept the held word in the very cycle the next frame completes
      @(negedge m_clock);
      fork
         drive_bits(1'b0, frame(1'b0, 9'h33, 1'b0), 10);
         begin
            repeat (154) @(posedge m_clock);
            #1;
            chk("pre-accept data", data_a, 8'h11);
            ready_a = 1;
            @(posedge m_clock); #1;
            chk("accept valid", valid_a, 1);
            chk("accept data", data_a, 8'h33);
            chk("accept no overrun", ovr_a, 0);
            ready_a = 0;
         end
      join
      // reset in the middle of data bit 4 while a word is held
      @(negedge m_clock);
      fork
         drive_bits(1'b0, frame(1'b0, 9'h5A, 1'b0), 10);
         begin
            repeat (82) @(posedge m_clock);
            #2;
            chk("pre-reset busy", busy_a, 1);
            chk("pre-reset valid", valid_a, 1);
            p_reset = 0;
            #1;
            chk("midrst valid", valid_a, 0);
            chk("midrst data", data_a, 0);
            chk("midrst flags", {perr_a, ferr_a, ovr_a}, 0);
            chk("midrst busy", busy_a, 0);
         end
      join
      @(negedge m_clock);
      p_reset = 1;
      ready_a = 1;
      repeat (3) @(negedge m_clock);
      v1 = '{1'b0, 9'h7E, 1'b0, 9'h7E, 1'b0, 155};
      run_vec(v1, "after reset");
      chk("final idle a", busy_a, 0);
      chk("final idle b", busy_b, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
